decoder_scan_sequencer: RTL and testbench



---
 rtl/decoder_scan_sequencer.sv | 141 ++++++++++++++
 tb/tb_decoder_scan_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_scan_sequencer.sv
// ============================================================================
// Module      : decoder_scan_sequencer
// Description : Address/enable sequencer feeding a 3-to-8 decoder. Steps the
//               select through all 8 codes with a programmable dwell and one
//               blanking cycle between codes; one-shot or continuous scan.
//               Optional macro SCAN_REVERSE_EN sweeps 7 down to 0 instead.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decoder_scan_sequencer #(
  parameter int DWELL_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic single,
  input  logic stop,
  output logic e,
  output logic a,
  output logic b,
  output logic c,
  output logic busy,
  output logic sweep_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_BLANK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [7:0] c_last_count = 8'(DWELL_CYCLES - 1);

`ifdef SCAN_REVERSE_EN
  localparam logic [2:0] c_first_addr = 3'd7;
  localparam logic [2:0] c_final_addr = 3'd0;
  localparam logic [2:0] c_addr_step  = 3'd7;  // modulo-8 decrement
`else
  localparam logic [2:0] c_first_addr = 3'd0;
  localparam logic [2:0] c_final_addr = 3'd7;
  localparam logic [2:0] c_addr_step  = 3'd1;
`endif

  state_t     state_q, state_d;
  logic [2:0] addr_q, addr_d;
  logic [7:0] count_q, count_d;
  logic       mode_q, mode_d;
  logic       e_q, e_d;
  logic       busy_q, busy_d;
  logic       sweep_done_q, sweep_done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= 3'd0;
      count_q      <= 8'd0;
      mode_q       <= 1'b0;
      e_q          <= 1'b0;
      busy_q       <= 1'b0;
      sweep_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      count_q      <= count_d;
      mode_q       <= mode_d;
      e_q          <= e_d;
      busy_q       <= busy_d;
      sweep_done_q <= sweep_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    count_d      = count_q;
    mode_d       = mode_q;
    sweep_done_d = 1'b0;

    // Abort wins over everything once a sweep is under way.
    if (state_q != S_IDLE && stop) begin
      state_d = S_IDLE;
      addr_d  = 3'd0;
      count_d = 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          addr_d  = 3'd0;
          count_d = 8'd0;
          if (start && !stop) begin
            state_d = S_DRIVE;
            addr_d  = c_first_addr;
            mode_d  = single;
          end
        end
        S_DRIVE: begin
          if (count_q == c_last_count) begin
            count_d = 8'd0;
            if (addr_q == c_final_addr && mode_q) begin
              state_d      = S_DONE;
              sweep_done_d = 1'b1;
            end else begin
              state_d      = S_BLANK;
              addr_d       = addr_q + c_addr_step;
              sweep_done_d = (addr_q == c_final_addr);
            end
          end else begin
            count_d = count_q + 8'd1;
          end
        end
        S_BLANK: begin
          state_d = S_DRIVE;
        end
        S_DONE: begin
          state_d = S_IDLE;
          addr_d  = 3'd0;
        end
        default: begin
          state_d = S_IDLE;
          addr_d  = 3'd0;
          count_d = 8'd0;
        end
      endcase
    end

    // Outputs are registered from the next state so they line up with it.
    e_d    = (state_d == S_DRIVE);
    busy_d = (state_d != S_IDLE);
  end

  assign e          = e_q;
  assign a          = addr_q[2];
  assign b          = addr_q[1];
  assign c          = addr_q[0];
  assign busy       = busy_q;
  assign sweep_done = sweep_done_q;

endmodule

`default_nettype wire

// File: tb/tb_decoder_scan_sequencer.sv
// ============================================================================
// Module      : tb_decoder_scan_sequencer
// Description : Self-checking bench for decoder_scan_sequencer; three DUTs
//               with dwell 1, 2 and 3 against a timeline-arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decoder_scan_sequencer;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst, start, single, stop;

  logic e0, a0, b0, c0, busy0, sd0;
  logic e1, a1, b1, c1, busy1, sd1;
  logic e2, a2, b2, c2, busy2, sd2;
  logic [5:0] dut_out [N];

  always #5 clk = ~clk;

  decoder_scan_sequencer #(.DWELL_CYCLES(1)) u_dw1 (
    .clk(clk), .rst(rst), .start(start), .single(single), .stop(stop),
    .e(e0), .a(a0), .b(b0), .c(c0), .busy(busy0), .sweep_done(sd0));
  decoder_scan_sequencer #(.DWELL_CYCLES(2)) u_dw2 (
    .clk(clk), .rst(rst), .start(start), .single(single), .stop(stop),
    .e(e1), .a(a1), .b(b1), .c(c1), .busy(busy1), .sweep_done(sd1));
  decoder_scan_sequencer #(.DWELL_CYCLES(3)) u_dw3 (
    .clk(clk), .rst(rst), .start(start), .single(single), .stop(stop),
    .e(e2), .a(a2), .b(b2), .c(c2), .busy(busy2), .sweep_done(sd2));

  // Packed as {e, a, b, c, busy, sweep_done}
  assign dut_out[0] = {e0, a0, b0, c0, busy0, sd0};
  assign dut_out[1] = {e1, a1, b1, c1, busy1, sd1};
  assign dut_out[2] = {e2, a2, b2, c2, busy2, sd2};

  bit m_act  [N];
  int m_k    [N];
  bit m_mode [N];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    bit rst;
    bit start;
    bit single;
    bit stop;
    bit e;
    int idx;
    bit busy;
    bit sd;
  } vec_t;

  vec_t vecs [12];

  function automatic logic [2:0] map_addr(int idx);
`ifdef SCAN_REVERSE_EN
    return 3'(7 - idx);
`else
    return 3'(idx);
`endif
  endfunction

  // Cycle k (1-based) after an accepted start: each address occupies d+1
  // cycles (d driven, then one blank/done cycle).
  function automatic logic [5:0] model_out(int d, bit act, int k, bit mode);
    int per, p, idx, w;
    if (!act) return 6'b0;
    per = 8 * (d + 1);
    p   = (k - 1) % per;
    idx = p / (d + 1);
    w   = p % (d + 1);
    if (w < d) return {1'b1, map_addr(idx), 1'b1, 1'b0};
    if (idx == 7 && mode) return {1'b0, map_addr(7), 1'b1, 1'b1};
    return {1'b0, map_addr((idx + 1) % 8), 1'b1, (idx == 7)};
  endfunction

  task automatic model_edge();
    for (int i = 0; i < N; i++) begin
      int per;
      per = 8 * (i + 2);
      if (rst) m_act[i] = 1'b0;
      else if (m_act[i]) begin
        if (stop) m_act[i] = 1'b0;
        else begin
          m_k[i]++;
          if (m_mode[i] && m_k[i] > per) m_act[i] = 1'b0;
        end
      end else if (start && !stop) begin
        m_act[i]  = 1'b1;
        m_k[i]    = 1;
        m_mode[i] = single;
      end
    end
  endtask

  task automatic check_vec(string name, logic [5:0] got, logic [5:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc %0d: got %b want %b (e,abc,busy,sd)", name, cyc, got, want);
    end
  endtask

  task automatic check_int(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s cyc %0d: got %0d want %0d", name, cyc, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
    for (int i = 0; i < N; i++)
      check_vec($sformatf("model_dw%0d", i + 1), dut_out[i],
                model_out(i + 1, m_act[i], m_k[i], m_mode[i]));
  endtask

  initial begin
    int sd_at, sd_b, sd_c, busy25, gap_busy, re_e;
    int sd_times[$];
    bit found;
    logic [5:0] want;

    rst = 1'b1; start = 1'b1; single = 1'b0; stop = 1'b0;

    // Directed table, expectations for the dwell-2 instance
    vecs[0]  = '{1, 1, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{1, 1, 0, 0, 0, 0, 0, 0};
    vecs[2]  = '{0, 1, 0, 1, 0, 0, 0, 0};
    vecs[3]  = '{0, 1, 1, 0, 1, 0, 1, 0};
    vecs[4]  = '{0, 0, 1, 0, 1, 0, 1, 0};
    vecs[5]  = '{0, 0, 0, 0, 0, 1, 1, 0};
    vecs[6]  = '{0, 0, 0, 0, 1, 1, 1, 0};
    vecs[7]  = '{0, 0, 0, 1, 0, 0, 0, 0};
    vecs[8]  = '{0, 1, 0, 1, 0, 0, 0, 0};
    vecs[9]  = '{0, 1, 0, 0, 1, 0, 1, 0};
    vecs[10] = '{0, 1, 1, 0, 1, 0, 1, 0};
    vecs[11] = '{1, 0, 0, 0, 0, 0, 0, 0};

    for (int v = 0; v < 12; v++) begin
      rst = vecs[v].rst; start = vecs[v].start;
      single = vecs[v].single; stop = vecs[v].stop;
      tick();
      want = {vecs[v].e, (vecs[v].busy ? map_addr(vecs[v].idx) : 3'd0),
              vecs[v].busy, vecs[v].sd};
      check_vec($sformatf("vec%0d", v), dut_out[1], want);
    end
    rst = 1'b0; start = 1'b0; single = 1'b0; stop = 1'b0;

    // One-shot sweep: sweep_done at T+8D+8, idle the cycle after
    sd_at = -1; sd_b = -1; sd_c = -1; busy25 = 1;
    start = 1'b1; single = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      start = 1'b0;
      if (dut_out[1][0] && sd_at < 0) sd_at = n;
      if (dut_out[2][0] && sd_b < 0) sd_b = n;
      if (dut_out[0][0] && sd_c < 0) sd_c = n;
      if (n == 25) busy25 = int'(dut_out[1][1]);
    end
    check_int("oneshot_sd_dw2", sd_at, 24);
    check_int("oneshot_busy_dw2", busy25, 0);
    check_int("oneshot_sd_dw3", sd_b, 32);
    check_int("oneshot_sd_dw1", sd_c, 16);

    // Continuous scan with an ignored mid-sweep start/single pulse
    start = 1'b1; single = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      tick();
      start  = (n == 10);
      single = (n == 10);
      if (dut_out[2][0]) sd_times.push_back(n);
    end
    check_int("cont_sd_count", sd_times.size(), 3);
    for (int j = 0; j < 3; j++)
      check_int($sformatf("cont_sd%0d", j),
                (j < sd_times.size()) ? sd_times[j] : -1, 32 * (j + 1));
    stop = 1'b1; tick(); stop = 1'b0;

    // Abort while the dwell-2 instance drives address 5
    start = 1'b1; single = 1'b0;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 80 && !found; n++) begin
      if (dut_out[1][5] && dut_out[1][4:2] == 3'd5) found = 1'b1;
      else tick();
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL abort_wait cyc %0d: got timeout want addr 5 driven", cyc);
    end else begin
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check_vec("abort_idle", dut_out[1], 6'b0);
      start = 1'b1; single = 1'b1;
      tick();
      start = 1'b0;
      check_vec("restart_first", dut_out[1], {1'b1, map_addr(0), 1'b1, 1'b0});
    end
    stop = 1'b1; tick(); stop = 1'b0;

    // start held with single=1: exactly one idle cycle before re-arm
    sd_at = -1; gap_busy = 1; re_e = 0;
    start = 1'b1; single = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      tick();
      if (sd_at > 0 && n == sd_at + 1) gap_busy = int'(dut_out[1][1]);
      if (sd_at > 0 && n == sd_at + 2) re_e = int'(dut_out[1][5]);
      if (dut_out[1][0] && sd_at < 0) sd_at = n;
    end
    check_int("held_sd", sd_at, 24);
    check_int("held_gap_busy", gap_busy, 0);
    check_int("held_rearm_e", re_e, 1);
    start = 1'b0; stop = 1'b1; tick(); stop = 1'b0;

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst    = ($urandom % 100) == 0;
      stop   = ($urandom % 40) == 0;
      start  = ($urandom % 6) == 0;
      single = 1'($urandom % 2);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
